// File: rtl/genie_merge_wrr.sv
// Packet-aware N:1 merge with weighted round-robin arbitration and a 2-entry registered skid output.
// Optional per-input packet counters on o_pkt_count when GENIE_MERGE_WRR_STATS_EN is defined.
module genie_merge_wrr #(
  parameter int NI    = 4,
  parameter int WIDTH = 32,
  parameter int WBITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NI-1:0][WIDTH-1:0]    i_data,
  input  logic [NI-1:0]               i_valid,
  input  logic [NI-1:0]               i_eop,
  output logic [NI-1:0]               o_ready,
  input  logic [NI-1:0][WBITS-1:0]    i_weight,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_valid,
  output logic                        o_eop,
  input  logic                        i_ready
`ifdef GENIE_MERGE_WRR_STATS_EN
  ,
  output logic [NI-1:0][31:0]         o_pkt_count
`endif
);

  localparam int          NIBITS = $clog2(NI);
  localparam int unsigned NI_U   = NI;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        state_q,  state_d;
  logic [NIBITS-1:0] grant_q,  grant_d;
  logic [WBITS-1:0]  credit_q, credit_d;
  logic [1:0]        count_q,  count_d;
  logic [WIDTH-1:0]  data0_q,  data0_d;
  logic [WIDTH-1:0]  data1_q,  data1_d;
  logic              eop0_q,   eop0_d;
  logic              eop1_q,   eop1_d;

  logic              keep;
  logic              hit_found;
  logic [NIBITS-1:0] hit_idx;
  logic              ready_g;
  logic              acc;
  logic              pop;
  logic [WIDTH-1:0]  beat_data;
  logic              beat_eop;

  function automatic logic [WBITS-1:0] quota(input logic [WBITS-1:0] w);
    return (w == '0) ? WBITS'(1) : w;
  endfunction

  // Holder keeps the grant at a packet boundary only while it has credit and a beat waiting.
  assign keep      = (credit_q != '0) && i_valid[grant_q];
  assign beat_data = i_data[grant_q];
  assign beat_eop  = i_eop[grant_q];

  // Round-robin search starting one past the holder; the holder itself is the last candidate.
  always_comb begin
    logic [NIBITS-1:0] idx;
    hit_found = 1'b0;
    hit_idx   = grant_q;
    idx       = grant_q;
    for (int unsigned k = 1; k <= NI_U; k++) begin
      idx = NIBITS'((32'(grant_q) + k) % NI_U);
      if (!hit_found && i_valid[idx]) begin
        hit_found = 1'b1;
        hit_idx   = idx;
      end
    end
  end

  always_comb begin
    ready_g = !reset && (count_q != 2'd2) && !((state_q == S_IDLE) && !keep);
    o_ready = '0;
    o_ready[grant_q] = ready_g;
  end

  assign acc = i_valid[grant_q] && ready_g;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    case (state_q)
      S_IDLE: begin
        if (!keep) begin
          if (hit_found) begin
            grant_d  = hit_idx;
            credit_d = quota(i_weight[hit_idx]);
          end
        end else if (acc) begin
          if (beat_eop) begin
            if (credit_q != '0) credit_d = credit_q - WBITS'(1);
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (acc && beat_eop) begin
          state_d = S_IDLE;
          if (credit_q != '0) credit_d = credit_q - WBITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = (count_q != 2'd0) && i_ready;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    eop0_d  = eop0_q;
    eop1_d  = eop1_q;
    case ({acc, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          data0_d = beat_data;
          eop0_d  = beat_eop;
        end else begin
          data1_d = beat_data;
          eop1_d  = beat_eop;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        data0_d = data1_q;
        eop0_d  = eop1_q;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          data0_d = data1_q;
          eop0_d  = eop1_q;
          data1_d = beat_data;
          eop1_d  = beat_eop;
        end else begin
          data0_d = beat_data;
          eop0_d  = beat_eop;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      credit_q <= quota(i_weight[0]);
      count_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      eop0_q   <= 1'b0;
      eop1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      eop0_q   <= eop0_d;
      eop1_q   <= eop1_d;
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = data0_q;
  assign o_eop   = eop0_q;

`ifdef GENIE_MERGE_WRR_STATS_EN
  logic [NI-1:0][31:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else if (acc && beat_eop) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
    end
  end

  assign o_pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_genie_merge_wrr.sv
// Scoreboard bench for genie_merge_wrr: a packet-level WRR model predicts the output beat stream.
// Checks o_pkt_count as well when GENIE_MERGE_WRR_STATS_EN is defined.
module tb_genie_merge_wrr;

  localparam int NI    = 4;
  localparam int WIDTH = 32;
  localparam int WBITS = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             e;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NI-1:0][WIDTH-1:0] i_data;
  logic [NI-1:0]            i_valid;
  logic [NI-1:0]            i_eop;
  logic [NI-1:0]            o_ready;
  logic [NI-1:0][WBITS-1:0] i_weight;
  logic [WIDTH-1:0]         o_data;
  logic                     o_valid;
  logic                     o_eop;
  logic                     i_ready;
`ifdef GENIE_MERGE_WRR_STATS_EN
  logic [NI-1:0][31:0]      o_pkt_count;
`endif

  genie_merge_wrr #(.NI(NI), .WIDTH(WIDTH), .WBITS(WBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_eop    (i_eop),
    .o_ready  (o_ready),
    .i_weight (i_weight),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_eop    (o_eop),
    .i_ready  (i_ready)
`ifdef GENIE_MERGE_WRR_STATS_EN
    ,
    .o_pkt_count (o_pkt_count)
`endif
  );

  always #5 clk = ~clk;

  beat_t         inq [NI][$];
  beat_t         expq[$];
  logic [NI-1:0] first_beat = '1;
  int            nvec = 0;
  int            nerr = 0;
  int            rdy_pct = 100;
  int            gap_pct = 0;
  bit            stall = 1'b0;
  bit            allow_extra = 1'b1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Input drivers: handshake is sampled mid-cycle and committed after the following edge.
  initial begin
    logic [NI-1:0] fire;
    i_valid = '0;
    i_data  = '0;
    i_eop   = '0;
    i_ready = 1'b0;
    forever begin
      @(negedge clk);
      fire = i_valid & o_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (fire[i] && inq[i].size() > 0) begin
          first_beat[i] = inq[i][0].e;
          void'(inq[i].pop_front());
        end
        if (inq[i].size() > 0) begin
          i_valid[i] = first_beat[i] || ($urandom_range(0, 99) >= gap_pct);
          i_data[i]  = inq[i][0].d;
          i_eop[i]   = inq[i][0].e;
        end else begin
          i_valid[i] = 1'b0;
          i_data[i]  = '0;
          i_eop[i]   = 1'b0;
        end
      end
      i_ready = !stall && ($urandom_range(1, 100) <= rdy_pct);
    end
  end

  // Output monitor: every beat leaving the merge is compared against the scoreboard head.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (!reset && o_valid && i_ready) begin
        if (expq.size() > 0) begin
          exp_b = expq.pop_front();
          nvec++;
          if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
            nerr++;
            $display("FAIL beat: got data=%h eop=%b, expected data=%h eop=%b",
                     o_data, o_eop, exp_b.d, exp_b.e);
          end
        end else if (!allow_extra) begin
          nvec++;
          nerr++;
          $display("FAIL extra_beat: got data=%h eop=%b, expected no beat", o_data, o_eop);
        end
      end
    end
  end

  // Packet-level WRR reference: each packet costs one credit, an exhausted or idle holder
  // passes the grant to the next active input after it (itself last), reloading max(weight,1).
  task automatic build(input logic [NI-1:0] mask, input logic [NI-1:0][WBITS-1:0] w,
                       input int lmin, input int lmax, input int npk, input int pad);
    int g;
    int c;
    int len;
    beat_t b;
    g = 0;
    c = (w[0] == '0) ? 1 : int'(w[0]);
    for (int p = 0; p < npk; p++) begin
      if (!(c > 0 && mask[g])) begin
        for (int k = 1; k <= NI; k++) begin
          if (mask[(g + k) % NI]) begin
            g = (g + k) % NI;
            break;
          end
        end
        c = (w[g] == '0) ? 1 : int'(w[g]);
      end
      c--;
      len = $urandom_range(lmax, lmin);
      for (int j = 0; j < len; j++) begin
        b.d = {8'(g), 24'($urandom)};
        b.e = (j == len - 1);
        inq[g].push_back(b);
        expq.push_back(b);
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (mask[i]) begin
        for (int q = 0; q < pad; q++) begin
          len = $urandom_range(lmax, lmin);
          for (int j = 0; j < len; j++) begin
            b.d = {8'(i), 24'($urandom)};
            b.e = (j == len - 1);
            inq[i].push_back(b);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    check({nm, "_rst_ready0"}, 64'(o_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_rst_valid"}, 64'(o_valid), 64'd0);
    check({nm, "_rst_ready1"}, 64'(o_ready), 64'd0);
`ifdef GENIE_MERGE_WRR_STATS_EN
    for (int i = 0; i < NI; i++) check({nm, "_rst_pktcnt"}, 64'(o_pkt_count[i]), 64'd0);
`endif
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic run_test(input string nm, input logic [NI-1:0] mask,
                          input logic [NI-1:0][WBITS-1:0] w, input int lmin, input int lmax,
                          input int rdy, input int gap, input int npk, input int pad,
                          input bit do_stall);
    int budget;
    @(posedge clk);
    #3;
    reset       = 1'b1;
    stall       = 1'b0;
    allow_extra = 1'b1;
    i_weight    = w;
    rdy_pct     = rdy;
    gap_pct     = gap;
    for (int i = 0; i < NI; i++) inq[i].delete();
    expq.delete();
    first_beat = '1;
    build(mask, w, lmin, lmax, npk, pad);
    do_reset(nm);
    allow_extra = (pad > 0);
    if (do_stall) begin
      repeat (3) @(posedge clk);
      #3;
      stall = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check({nm, "_stall_ready"}, 64'(o_ready), 64'd0);
      check({nm, "_stall_valid"}, 64'(o_valid), 64'd1);
      @(posedge clk);
      #3;
      stall = 1'b0;
    end
    budget = 0;
    while (expq.size() > 0 && budget < 4000) begin
      @(posedge clk);
      budget++;
    end
    if (expq.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", nm, expq.size());
      expq.delete();
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    logic [NI-1:0][WBITS-1:0] w;
    logic [NI-1:0]            m;
    i_weight = '0;

    w = {4'd3, 4'd1, 4'd2, 4'd1};
    run_test("wrr_share", 4'b1111, w, 1, 1, 100, 0, 28, 3, 1'b0);

    w = {4'd1, 4'd1, 4'd1, 4'd1};
    run_test("pkt_lock", 4'b0011, w, 5, 5, 100, 0, 6, 2, 1'b0);
    run_test("pkt_lock_rand", 4'b0011, w, 1, 5, 70, 25, 12, 2, 1'b0);

    w = {4'd1, 4'd1, 4'd1, 4'd2};
    run_test("backpressure", 4'b0001, w, 6, 8, 100, 0, 5, 0, 1'b1);

    w = {4'd1, 4'd0, 4'd1, 4'd1};
    run_test("lone_w0", 4'b0100, w, 1, 1, 100, 0, 10, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NI; i++) w[i] = 4'($urandom_range(0, 4));
      run_test("random", m, w, 1, 4, $urandom_range(30, 100), 20, 25, 3, 1'b0);
    end

    w = {4'd2, 4'd1, 4'd1, 4'd1};
    run_test("stats", 4'b1000, w, 1, 3, 100, 0, 7, 0, 1'b0);
`ifdef GENIE_MERGE_WRR_STATS_EN
    @(negedge clk);
    check("stats_in3", 64'(o_pkt_count[3]), 64'd7);
    for (int i = 0; i < 3; i++) check("stats_other", 64'(o_pkt_count[i]), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    do_reset("stats_clear");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "watchdog expired");
  end

endmodule
